// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO plus transmit sequencer that sits between the regbank read path
//   and uart_tx. The producer may push one byte per clock; the sequencer drains
//   the queue one byte at a time. For each byte it presents tx_data, pulses
//   tx_trigger, then waits for uart_tx to report the frame finished before
//   moving on. At most one frame is outstanding at any time.
//
// Ports
//   clk         in   1      system clock
//   rst_n       in   1      asynchronous active-low reset
//   wr_en       in   1      push request, one byte per cycle
//   wr_data     in   8      byte to push
//   tx_busy     in   1      high while uart_tx is sending a frame
//   tx_data     out  8      byte presented to uart_tx (held until the next load)
//   tx_trigger  out  1      one-cycle start pulse to uart_tx
//   full        out  1      count == DEPTH
//   empty       out  1      count == 0
//   count       out  AW+1   current occupancy, 0..DEPTH
//   overflow    out  1      one-cycle pulse the cycle after a push is dropped
module uart_tx_fifo #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int GAP_CYC = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          tx_busy,
    output logic [7:0]    tx_data,
    output logic          tx_trigger,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        TRIG,
        WSTART,
        WDONE,
        GAP
    } state_t;

    // Number of cycles to wait for uart_tx to acknowledge a trigger by
    // raising tx_busy before giving up on that byte.
    localparam int            StartTimeout = 16;
    localparam logic [3:0]    WaitLast     = 4'(StartTimeout - 1);
    localparam logic [AW:0]   FullCount    = (AW + 1)'(DEPTH);
    localparam logic [7:0]    GapLoad      = 8'(GAP_CYC);

    logic [7:0]    mem [DEPTH];

    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q;

    state_t        state_q;
    logic [7:0]    txData_q;
    logic          txTrigger_q;
    logic [7:0]    gapCnt_q;
    logic [3:0]    waitCnt_q;

    logic          pushOk;
    logic          popNow;

    assign full       = (count_q == FullCount);
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign tx_data    = txData_q;
    assign tx_trigger = txTrigger_q;

    // A push is only accepted against the registered full flag, so a pop in
    // the same cycle never makes room for a push that arrives while full.
    // The only consumer of the queue is the sequencer's LOAD state.
    assign pushOk = wr_en && !full;
    assign popNow = (state_q == LOAD);

    // Next-state for pointers and occupancy. Pointers are AW bits wide and
    // wrap naturally from DEPTH-1 back to 0. A simultaneous push and pop
    // leaves the occupancy unchanged.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushOk) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (popNow) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        case ({pushOk, popNow})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array. It carries no reset: stale contents are never visible
    // because reads are gated by the occupancy count.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem[wrPtr_q] <= wr_data;
        end
    end

    // Pointer, occupancy and overflow registers. overflow is a registered
    // pulse, so it appears the cycle after the dropped push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= wr_en && full;
        end
    end

    // Transmit sequencer. tx_trigger is registered: it is set while leaving
    // LOAD so that it is high for exactly the TRIG cycle. tx_data is only
    // written in LOAD, so it stays stable for the whole frame. A frame that
    // uart_tx never acknowledges is abandoned after the start timeout and
    // treated as sent; the byte is not retried.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            txData_q    <= 8'h00;
            txTrigger_q <= 1'b0;
            gapCnt_q    <= 8'h00;
            waitCnt_q   <= 4'h0;
        end else begin
            txTrigger_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!empty && !tx_busy) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    txData_q    <= mem[rdPtr_q];
                    txTrigger_q <= 1'b1;
                    state_q     <= TRIG;
                end
                TRIG: begin
                    waitCnt_q <= 4'h0;
                    state_q   <= WSTART;
                end
                WSTART: begin
                    if (tx_busy) begin
                        state_q <= WDONE;
                    end else if (waitCnt_q == WaitLast) begin
                        gapCnt_q <= GapLoad;
                        state_q  <= GAP;
                    end else begin
                        waitCnt_q <= waitCnt_q + 4'h1;
                    end
                end
                WDONE: begin
                    if (!tx_busy) begin
                        gapCnt_q <= GapLoad;
                        state_q  <= GAP;
                    end
                end
                GAP: begin
                    // A load of 0 or 1 both leave after a single GAP cycle.
                    if (gapCnt_q <= 8'h01) begin
                        gapCnt_q <= 8'h00;
                        state_q  <= IDLE;
                    end else begin
                        gapCnt_q <= gapCnt_q - 8'h01;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Self-checking bench for uart_tx_fifo. A behavioural uart_tx stand-in
//   raises tx_busy for a frame after each trigger; a queue model of the FIFO
//   predicts occupancy, overflow pulses and the byte order on the wire.
module tb_uart_tx_fifo;

    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int GAP_CYC = 2;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          tx_busy;
    logic [7:0]    tx_data;
    logic          tx_trigger;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model state: bytes accepted but not yet triggered, the byte
    // expected on each trigger, what was actually triggered, and when.
    logic [7:0] expQ[$];
    logic [8:0] expSent[$];
    logic [8:0] sentQ[$];
    int         trigCycles[$];
    int         busyLeft    = 0;
    int         frameLen    = 4;
    bit         busyNever   = 1'b0;
    bit         randFrames  = 1'b0;
    bit         dropPending = 1'b0;
    bit         expOvf      = 1'b0;
    int         expCount    = 0;

    uart_tx_fifo #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .GAP_CYC(GAP_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_trigger(tx_trigger),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle seen from the falling edge: record any trigger, run the
    // uart_tx stand-in, update the FIFO model, then drive the next push.
    task automatic tick(input bit we, input logic [7:0] d);
        @(negedge clk);
        cycle++;
        expOvf      = dropPending;
        dropPending = 1'b0;
        if (tx_trigger === 1'b1) begin
            sentQ.push_back({1'b0, tx_data});
            trigCycles.push_back(cycle);
            if (expQ.size() > 0) expSent.push_back({1'b0, expQ.pop_front()});
            else                 expSent.push_back(9'h1FF);
            if (!busyNever) begin
                busyLeft = randFrames ? int'($urandom_range(12, 2)) : frameLen;
                tx_busy  = 1'b1;
            end
        end else if (busyLeft > 0) begin
            busyLeft--;
            if (busyLeft == 0) tx_busy = 1'b0;
        end
        expCount = expQ.size();
        wr_en    = we;
        wr_data  = d;
        if (we) begin
            if (expQ.size() < DEPTH) expQ.push_back(d);
            else                     dropPending = 1'b1;
        end
    endtask

    // Idle until the model queue and the frame in flight are finished, then
    // allow enough cycles for any timeout and inter-frame gap to elapse.
    task automatic drain(input int maxCycles, output bit ok);
        int n = 0;
        while ((expQ.size() != 0 || tx_busy) && n < maxCycles) begin
            tick(1'b0, 8'h00);
            n++;
        end
        ok = (n < maxCycles);
        repeat (24) tick(1'b0, 8'h00);
    endtask

    task automatic test_reset();
        wr_en   = 1'b0;
        wr_data = 8'h00;
        tx_busy = 1'b0;
        rst_n   = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        checks++;
        if ({tx_data, tx_trigger, overflow, full, empty, count} !==
            {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0}) begin
            errors++;
            $display("[TB] FAIL reset_values got data=%h trig=%b ovf=%b full=%b empty=%b count=%0d want 00 0 0 0 1 0",
                     tx_data, tx_trigger, overflow, full, empty, count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_byte();
        bit ok;
        frameLen = 4;
        tick(1'b1, 8'hA5);
        tick(1'b0, 8'h00);
        checks++;
        if (count !== 5'd1 || empty !== 1'b0 || tx_trigger !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_after_push got count=%0d empty=%b trig=%b want 1 0 0", count, empty, tx_trigger);
        end
        tick(1'b0, 8'h00);
        checks++;
        if (tx_trigger !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_early_trigger got %b want 0", tx_trigger);
        end
        tick(1'b0, 8'h00);
        checks++;
        if (tx_trigger !== 1'b1 || tx_data !== 8'hA5 || count !== 5'd0 || empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_trigger got trig=%b data=%h count=%0d empty=%b want 1 a5 0 1",
                     tx_trigger, tx_data, count, empty);
        end
        drain(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL single_drain_timeout got busy=%b want drained", tx_busy);
        end
    endtask

    task automatic test_back_to_back();
        // Pretend uart_tx is already busy so the FIFO can fill completely.
        busyLeft = 40;
        tx_busy  = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick(1'b1, 8'(i));
        tick(1'b0, 8'h00);
        checks++;
        if (count !== 5'd16 || full !== 1'b1 || empty !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill_full got count=%0d full=%b empty=%b want 16 1 0", count, full, empty);
        end
        checks++;
        if (count !== expCount) begin
            errors++;
            $display("[TB] FAIL fill_model got count=%0d want %0d", count, expCount);
        end
    endtask

    task automatic test_overflow();
        tick(1'b1, 8'hFF);
        tick(1'b0, 8'h00);
        checks++;
        if (overflow !== 1'b1 || overflow !== expOvf || count !== 5'd16) begin
            errors++;
            $display("[TB] FAIL overflow_pulse got ovf=%b count=%0d want 1 16", overflow, count);
        end
        tick(1'b0, 8'h00);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overflow_one_cycle got %b want 0", overflow);
        end
    endtask

    task automatic test_drain_order();
        bit ok;
        int start = sentQ.size();
        int tStart = trigCycles.size();
        frameLen = 100;
        drain(DEPTH * 120 + 200, ok);
        checks++;
        if (!ok || sentQ.size() - start != DEPTH) begin
            errors++;
            $display("[TB] FAIL order_count got %0d frames want %0d", sentQ.size() - start, DEPTH);
        end
        for (int i = start; i < sentQ.size(); i++) begin
            checks++;
            if (sentQ[i] !== expSent[i] || sentQ[i] !== 9'(i - start)) begin
                errors++;
                $display("[TB] FAIL order[%0d] got %h want %h", i - start, sentQ[i], 9'(i - start));
            end
        end
        for (int i = tStart + 1; i < trigCycles.size(); i++) begin
            checks++;
            if (trigCycles[i] - trigCycles[i-1] != frameLen + GAP_CYC + 3 ||
                trigCycles[i] - trigCycles[i-1] - frameLen < GAP_CYC) begin
                errors++;
                $display("[TB] FAIL frame_period[%0d] got %0d want %0d",
                         i - tStart, trigCycles[i] - trigCycles[i-1], frameLen + GAP_CYC + 3);
            end
        end
    endtask

    task automatic test_pointer_wrap();
        bit ok;
        int n = 0;
        int start = sentQ.size();
        frameLen = 20;
        tick(1'b1, 8'($urandom));
        repeat (3) tick(1'b0, 8'h00);
        for (int i = 0; i < 5; i++) tick(1'b1, 8'($urandom));
        while (tx_busy && n < 60) begin
            tick(1'b0, 8'h00);
            n++;
        end
        repeat (3) tick(1'b0, 8'h00);
        // Sequencer is in LOAD this cycle: push lands alongside the pop.
        tick(1'b1, 8'($urandom));
        checks++;
        if (count !== 5'd5 || tx_trigger !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_push_before got count=%0d trig=%b want 5 0", count, tx_trigger);
        end
        tick(1'b0, 8'h00);
        checks++;
        if (count !== 5'd5 || tx_trigger !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_push_after got count=%0d trig=%b want 5 1", count, tx_trigger);
        end
        frameLen = 6;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 8'($urandom));
            checks++;
            if (count !== expCount) begin
                errors++;
                $display("[TB] FAIL wrap_count got %0d want %0d", count, expCount);
            end
        end
        drain(600, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL wrap_drain_timeout got busy=%b want drained", tx_busy);
        end
        for (int i = start; i < sentQ.size(); i++) begin
            checks++;
            if (sentQ[i] !== expSent[i]) begin
                errors++;
                $display("[TB] FAIL wrap_order[%0d] got %h want %h", i - start, sentQ[i], expSent[i]);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int start = sentQ.size();
        busyNever = 1'b1;
        tick(1'b1, 8'h5A);
        tick(1'b1, 8'hC3);
        drain(200, ok);
        busyNever = 1'b0;
        checks++;
        if (!ok || sentQ.size() - start != 2) begin
            errors++;
            $display("[TB] FAIL timeout_frames got %0d want 2", sentQ.size() - start);
        end else begin
            checks++;
            if (sentQ[start] !== 9'h05A || sentQ[start+1] !== 9'h0C3) begin
                errors++;
                $display("[TB] FAIL timeout_bytes got %h %h want 05a 0c3", sentQ[start], sentQ[start+1]);
            end
            checks++;
            if (trigCycles[start+1] - trigCycles[start] != 16 + GAP_CYC + 3) begin
                errors++;
                $display("[TB] FAIL timeout_spacing got %0d want %0d",
                         trigCycles[start+1] - trigCycles[start], 16 + GAP_CYC + 3);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int n;
        frameLen = 30;
        tick(1'b1, 8'($urandom));
        repeat (3) tick(1'b0, 8'h00);
        for (int i = 0; i < 4; i++) tick(1'b1, 8'($urandom));
        wr_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_data, tx_trigger, overflow, full, empty, count} !==
            {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0}) begin
            errors++;
            $display("[TB] FAIL midframe_reset got data=%h trig=%b ovf=%b full=%b empty=%b count=%0d want 00 0 0 0 1 0",
                     tx_data, tx_trigger, overflow, full, empty, count);
        end
        expQ.delete();
        busyLeft    = 0;
        tx_busy     = 1'b0;
        dropPending = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n = sentQ.size();
        repeat (30) tick(1'b0, 8'h00);
        checks++;
        if (sentQ.size() != n || count !== 5'd0) begin
            errors++;
            $display("[TB] FAIL midframe_no_trigger got %0d triggers count=%0d want 0 0", sentQ.size() - n, count);
        end
        tick(1'b1, 8'h3C);
        repeat (3) tick(1'b0, 8'h00);
        checks++;
        if (tx_trigger !== 1'b1 || tx_data !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL midframe_new_push got trig=%b data=%h want 1 3c", tx_trigger, tx_data);
        end
        drain(200, ok);
    endtask

    task automatic test_random_traffic();
        bit ok;
        int start = sentQ.size();
        randFrames = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick(($urandom_range(2, 0) == 0), 8'($urandom));
            checks++;
            if (count !== expCount || full !== (expCount == DEPTH) || empty !== (expCount == 0)) begin
                errors++;
                $display("[TB] FAIL rand_count[%0d] got count=%0d full=%b empty=%b want %0d",
                         i, count, full, empty, expCount);
            end
            checks++;
            if (overflow !== expOvf) begin
                errors++;
                $display("[TB] FAIL rand_overflow[%0d] got %b want %b", i, overflow, expOvf);
            end
        end
        drain(DEPTH * 40 + 200, ok);
        randFrames = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL rand_drain_timeout got busy=%b want drained", tx_busy);
        end
        for (int i = start; i < sentQ.size(); i++) begin
            checks++;
            if (sentQ[i] !== expSent[i]) begin
                errors++;
                $display("[TB] FAIL rand_order[%0d] got %h want %h", i - start, sentQ[i], expSent[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_drain_order();
        test_pointer_wrap();
        test_timeout();
        test_reset_mid_frame();
        test_random_traffic();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
